// File: rtl/array_tile_feeder_pkg.sv
// Shared constants, state encoding and helpers for the systolic-array tile feeder.
package array_tile_feeder_pkg;

    localparam int tile_dim    = 4;
    localparam int fetch_words = 2 * tile_dim;
    localparam logic [3:0] fetch_last = 4'd8;

    typedef enum logic [1:0] {
        st_idle    = 2'd0,
        st_fetch   = 2'd1,
        st_present = 2'd2,
        st_done    = 2'd3
    } feeder_state_e;

    // Staging words 0-3 hold A rows, 4-7 hold B columns.
    function automatic logic is_b_word(input logic [2:0] widx);
        return widx[2];
    endfunction

endpackage

// File: rtl/array_tile_feeder_if.sv
// Tile-RAM read port plus the tile/flag handshake toward the systolic array.
interface array_tile_feeder_if
    import array_tile_feeder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
);
    logic                                mem_rd_en;
    logic [ADDR_W-1:0]                   mem_addr;
    logic [tile_dim*WIDTH-1:0]           mem_rdata;
    logic                                tile_valid;
    logic                                tile_ready;
    logic [tile_dim*tile_dim*WIDTH-1:0]  a_tile;
    logic [tile_dim*tile_dim*WIDTH-1:0]  b_tile;
    logic                                add_flag;
    logic                                last_tile_flag;
    logic                                end_of_row_flag;
    logic                                end_of_head_flag;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output tile_valid,
        input  tile_ready,
        output a_tile, b_tile, add_flag, last_tile_flag, end_of_row_flag, end_of_head_flag
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  tile_valid,
        output tile_ready,
        input  a_tile, b_tile, add_flag, last_tile_flag, end_of_row_flag, end_of_head_flag
    );

endinterface

// File: rtl/array_tile_feeder_addr_gen.sv
// Row/col/k tile counters, boundary flags and tile-RAM word address generation.
module array_tile_feeder_addr_gen
    import array_tile_feeder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [CNT_W-1:0]  n_row,
    input  logic [CNT_W-1:0]  n_col,
    input  logic [CNT_W-1:0]  n_k,
    input  logic [2:0]        widx,
    output logic [ADDR_W-1:0] addr,
    output logic              add,
    output logic              last_tile,
    output logic              end_of_row,
    output logic              end_of_head
);

    logic [ADDR_W-1:0] a_base_r, b_base_r;
    logic [CNT_W-1:0]  n_row_r, n_col_r, n_k_r;
    logic [CNT_W-1:0]  r_r, c_r, k_r;
    logic [ADDR_W-1:0] tile_idx_s, base_s;

    localparam logic [CNT_W-1:0] cnt_one  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] cnt_zero = {CNT_W{1'b0}};

    // A zero count degenerates to a single tile along that axis.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] n);
        if (n == cnt_zero) begin
            return cnt_one;
        end else begin
            return n;
        end
    endfunction

    assign add         = (k_r != cnt_zero);
    assign last_tile   = (k_r == n_k_r - cnt_one);
    assign end_of_row  = last_tile && (c_r == n_col_r - cnt_one);
    assign end_of_head = end_of_row && (r_r == n_row_r - cnt_one);

    // Configuration latch and r-outer / c-middle / k-inner loop counters.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            a_base_r <= {ADDR_W{1'b0}};
            b_base_r <= {ADDR_W{1'b0}};
            n_row_r  <= cnt_zero;
            n_col_r  <= cnt_zero;
            n_k_r    <= cnt_zero;
            r_r      <= cnt_zero;
            c_r      <= cnt_zero;
            k_r      <= cnt_zero;
        end else if (load) begin
            a_base_r <= a_base;
            b_base_r <= b_base;
            n_row_r  <= eff_count(n_row);
            n_col_r  <= eff_count(n_col);
            n_k_r    <= eff_count(n_k);
            r_r      <= cnt_zero;
            c_r      <= cnt_zero;
            k_r      <= cnt_zero;
        end else if (advance) begin
            if (!last_tile) begin
                k_r <= k_r + cnt_one;
            end else begin
                k_r <= cnt_zero;
                if (c_r == n_col_r - cnt_one) begin
                    c_r <= cnt_zero;
                    r_r <= (r_r == n_row_r - cnt_one) ? cnt_zero : r_r + cnt_one;
                end else begin
                    c_r <= c_r + cnt_one;
                end
            end
        end
    end

    // Word address: base + (tile index * 4) + word-in-tile, wrapping at ADDR_W bits.
    always_comb begin
        tile_idx_s = {ADDR_W{1'b0}};
        base_s     = a_base_r;
        if (is_b_word(widx)) begin
            tile_idx_s = ADDR_W'(c_r) * ADDR_W'(n_k_r) + ADDR_W'(k_r);
            base_s     = b_base_r;
        end else begin
            tile_idx_s = ADDR_W'(r_r) * ADDR_W'(n_k_r) + ADDR_W'(k_r);
            base_s     = a_base_r;
        end
        addr = base_s + {tile_idx_s[ADDR_W-3:0], 2'b00} + ADDR_W'(widx[1:0]);
    end

endmodule

// File: rtl/array_tile_feeder.sv
// Initiator side of the systolic-array tile interface: fetches A/B tile pairs from the
// tile RAM and presents them, with boundary flags, one pair per valid/ready transfer.
module array_tile_feeder
    import array_tile_feeder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   a_base,
    input  logic [ADDR_W-1:0]   b_base,
    input  logic [CNT_W-1:0]    n_row,
    input  logic [CNT_W-1:0]    n_col,
    input  logic [CNT_W-1:0]    n_k,
    array_tile_feeder_if.master bus,
    output logic                busy,
    output logic                done
);

    localparam int word_w = tile_dim * WIDTH;

    feeder_state_e     state_r, state_s;
    logic [3:0]        fcnt_r, fcnt_s;
    logic [word_w-1:0] stage_r [fetch_words];
    logic              busy_r, done_r, valid_r;
    logic              load_s, advance_s, rd_en_s;
    logic              add_s, last_s, eor_s, eoh_s;
    logic [ADDR_W-1:0] addr_s;

    array_tile_feeder_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk         (clk),
        ._reset      (_reset),
        .load        (load_s),
        .advance     (advance_s),
        .a_base      (a_base),
        .b_base      (b_base),
        .n_row       (n_row),
        .n_col       (n_col),
        .n_k         (n_k),
        .widx        (fcnt_r[2:0]),
        .addr        (addr_s),
        .add         (add_s),
        .last_tile   (last_s),
        .end_of_row  (eor_s),
        .end_of_head (eoh_s)
    );

    // Next-state and control strobes for the fetch/present loop.
    always_comb begin
        state_s   = state_r;
        fcnt_s    = fcnt_r;
        load_s    = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            st_idle: begin
                if (start) begin
                    state_s = st_fetch;
                    fcnt_s  = 4'd0;
                    load_s  = 1'b1;
                end else begin
                    state_s = st_idle;
                end
            end
            st_fetch: begin
                if (fcnt_r == fetch_last) begin
                    state_s = st_present;
                    fcnt_s  = 4'd0;
                end else begin
                    fcnt_s  = fcnt_r + 4'd1;
                end
            end
            st_present: begin
                if (bus.tile_ready) begin
                    fcnt_s = 4'd0;
                    if (eoh_s) begin
                        state_s = st_done;
                    end else begin
                        state_s   = st_fetch;
                        advance_s = 1'b1;
                    end
                end else begin
                    state_s = st_present;
                end
            end
            st_done: begin
                state_s = st_idle;
            end
            default: begin
                state_s = st_idle;
                fcnt_s  = 4'd0;
            end
        endcase
    end

    // State, status registers and staging capture (RAM data lags the read by one cycle,
    // so fcnt 1..8 lands in words 0..7 via the 3-bit wrap of fcnt-1).
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_r <= st_idle;
            fcnt_r  <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            for (int i = 0; i < fetch_words; i++) begin
                stage_r[i] <= {word_w{1'b0}};
            end
        end else begin
            state_r <= state_s;
            fcnt_r  <= fcnt_s;
            busy_r  <= (state_s != st_idle);
            done_r  <= (state_s == st_done);
            valid_r <= (state_s == st_present);
            if ((state_r == st_fetch) && (fcnt_r != 4'd0)) begin
                stage_r[fcnt_r[2:0] - 3'd1] <= bus.mem_rdata;
            end
        end
    end

    assign rd_en_s              = (state_r == st_fetch) && (fcnt_r < fetch_last);
    assign bus.mem_rd_en        = rd_en_s;
    assign bus.mem_addr         = rd_en_s ? addr_s : {ADDR_W{1'b0}};
    assign bus.tile_valid       = valid_r;
    assign bus.a_tile           = {stage_r[3], stage_r[2], stage_r[1], stage_r[0]};
    assign bus.b_tile           = {stage_r[7], stage_r[6], stage_r[5], stage_r[4]};
    assign bus.add_flag         = add_s  && valid_r;
    assign bus.last_tile_flag   = last_s && valid_r;
    assign bus.end_of_row_flag  = eor_s  && valid_r;
    assign bus.end_of_head_flag = eoh_s  && valid_r;
    assign busy                 = busy_r;
    assign done                 = done_r;

endmodule

// File: tb/tb_array_tile_feeder.sv
// Directed + randomized bench for array_tile_feeder against a tile-RAM model and a
// loop-nest reference of the expected tile sequence.
module tb_array_tile_feeder;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         add;
        logic         last;
        logic         eor;
        logic         eoh;
    } tile_t;

    logic              clk = 1'b0;
    logic              _reset;
    logic              start;
    logic [ADDR_W-1:0] a_base, b_base;
    logic [CNT_W-1:0]  n_row, n_col, n_k;
    logic              busy, done;

    logic [31:0]  mem [1024];
    tile_t        exp_q[$];
    int           addr_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] first_a, first_b;

    always #5 clk = ~clk;

    array_tile_feeder_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    array_tile_feeder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        ._reset (_reset),
        .start  (start),
        .a_base (a_base),
        .b_base (b_base),
        .n_row  (n_row),
        .n_col  (n_col),
        .n_k    (n_k),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_tile"}, bus.a_tile, 128'd0);
        check({tag, "_b_tile"}, bus.b_tile, 128'd0);
        check({tag, "_ctl"}, 128'({bus.tile_valid, bus.add_flag, bus.last_tile_flag,
              bus.end_of_row_flag, bus.end_of_head_flag, busy, done, bus.mem_rd_en, bus.mem_addr}),
              128'd0);
    endtask

    // Expected tiles and read addresses, straight from the loop nest and packing rules.
    task automatic build_model(input int ab, input int bb, input int nr, input int nc, input int nk);
        int nre, nce, nke, wa, wb;
        tile_t t;
        logic [31:0] w;
        nre = (nr == 0) ? 1 : nr;
        nce = (nc == 0) ? 1 : nc;
        nke = (nk == 0) ? 1 : nk;
        for (int r = 0; r < nre; r++)
            for (int c = 0; c < nce; c++)
                for (int k = 0; k < nke; k++) begin
                    for (int i = 0; i < 4; i++) begin
                        wa = (ab + (r * nke + k) * 4 + i) % 1024;
                        addr_q.push_back(wa);
                        w = mem[wa];
                        for (int e = 0; e < 4; e++) t.a[(4 * i + e) * 8 +: 8] = w[e * 8 +: 8];
                    end
                    for (int j = 0; j < 4; j++) begin
                        wb = (bb + (c * nke + k) * 4 + j) % 1024;
                        addr_q.push_back(wb);
                        w = mem[wb];
                        for (int e = 0; e < 4; e++) t.b[(4 * j + e) * 8 +: 8] = w[e * 8 +: 8];
                    end
                    t.add  = (k != 0);
                    t.last = (k == nke - 1);
                    t.eor  = t.last && (c == nce - 1);
                    t.eoh  = t.eor && (r == nre - 1);
                    exp_q.push_back(t);
                end
    endtask

    // mode 0: ready tied high; 1: random ready; 2: five stall cycles per tile.
    task automatic run_head(input int ab, input int bb, input int nr, input int nc, input int nk,
                            input int mode, input bit glitch);
        int  cyc, stall, budget;
        bit  first, just_xfer;
        tile_t t;
        build_model(ab, bb, nr, nc, nk);
        budget = exp_q.size() * 40 + 40;
        @(negedge clk);
        a_base = 10'(ab); b_base = 10'(bb);
        n_row = 4'(nr); n_col = 4'(nc); n_k = 4'(nk);
        start = 1'b1;
        bus.tile_ready = (mode == 0);
        cyc = 0; stall = 0; first = 1'b1; just_xfer = 1'b0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_start", 128'({busy, done}), 128'(2'b10));
            if (just_xfer) check("valid_drops_on_xfer", 128'(bus.tile_valid), 128'(0));
            just_xfer = 1'b0;
            if (bus.mem_rd_en && addr_q.size() > 0)
                check("mem_addr", 128'(bus.mem_addr), 128'(addr_q.pop_front()));
            if (glitch && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                a_base = 10'($urandom); b_base = 10'($urandom);
                n_row = 4'($urandom); n_col = 4'($urandom); n_k = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            if (bus.tile_valid) begin
                t = exp_q[0];
                if (first) begin
                    check("start_to_valid_edges", 128'(cyc), 128'(10));
                    first_a = bus.a_tile;
                    first_b = bus.b_tile;
                    first = 1'b0;
                end
                check("a_tile", bus.a_tile, t.a);
                check("b_tile", bus.b_tile, t.b);
                check("flags", 128'({bus.add_flag, bus.last_tile_flag, bus.end_of_row_flag,
                      bus.end_of_head_flag}), 128'({t.add, t.last, t.eor, t.eoh}));
                if (mode == 0) bus.tile_ready = 1'b1;
                else if (mode == 1) bus.tile_ready = 1'($urandom_range(0, 1));
                else if (stall < 5) begin bus.tile_ready = 1'b0; stall++; end
                else bus.tile_ready = 1'b1;
                if (bus.tile_ready) begin
                    void'(exp_q.pop_front());
                    stall = 0;
                    just_xfer = 1'b1;
                end
            end else begin
                if (mode == 1) bus.tile_ready = 1'($urandom_range(0, 1));
                else bus.tile_ready = (mode == 0);
            end
        end
        start = 1'b0;
        check("tiles_outstanding", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        bus.tile_ready = 1'b0;
        check("valid_after_last", 128'(bus.tile_valid), 128'(0));
        check("done_pulse", 128'({done, busy}), 128'(2'b11));
        @(negedge clk);
        check("done_clear", 128'({done, busy}), 128'(2'b00));
        check("reads_outstanding", 128'(addr_q.size()), 128'(0));
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        bit saw;
        _reset = 1'b0; start = 1'b0;
        a_base = 10'd0; b_base = 10'd0; n_row = 4'd0; n_col = 4'd0; n_k = 4'd0;
        bus.tile_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        _reset = 1'b1;

        mem[100] = 32'h04030201; mem[101] = 32'h08070605;
        mem[102] = 32'h0c0b0a09; mem[103] = 32'h100f0e0d;
        for (int j = 0; j < 4; j++) mem[200 + j] = 32'h01010101;
        run_head(100, 200, 1, 1, 1, 0, 1'b0);
        check("single_a_packing", first_a, 128'h100f0e0d_0c0b0a09_08070605_04030201);
        check("single_b_packing", first_b, {16{8'h01}});

        run_head(16, 512, 2, 2, 2, 0, 1'b0);
        run_head(300, 40, 1, 2, 1, 2, 1'b0);

        // Reset while the second tile is at fcnt 3.
        @(negedge clk);
        a_base = 10'd500; b_base = 10'd600; n_row = 4'd1; n_col = 4'd1; n_k = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && !bus.tile_valid; i++) @(negedge clk);
        check("rst_tile1_valid", 128'(bus.tile_valid), 128'(1));
        bus.tile_ready = 1'b1;
        @(negedge clk);
        bus.tile_ready = 1'b0;
        check("rst_tile2_fetch", 128'(bus.mem_rd_en), 128'(1));
        repeat (3) @(negedge clk);
        check("rst_addr_fcnt3", 128'(bus.mem_addr), 128'(507));
        _reset = 1'b0;
        @(negedge clk);
        _reset = 1'b1;
        check_idle_outputs("rst_mid");
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw = saw | done | busy | bus.tile_valid;
        end
        check("rst_no_done", 128'(saw), 128'(0));
        run_head(64, 128, 2, 1, 2, 0, 1'b0);

        run_head(400, 700, 2, 2, 0, 0, 1'b1);
        run_head(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 3, 2, 4, 1, 1'b1);
        run_head(1016, 1020, 2, 1, 3, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
